// File: rtl/spi_sequencer.sv
// spi_sequencer: SPI master (CPOL=0, CPHA=0, MSB first) for the comparator
// DAC, pulse DAC, ADC and DDD serial ports.
// The host loads tx_data and target, then pulses start. The block runs one
// WIDTH-bit transfer and reports it with a one-cycle done pulse.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   start       request, sampled while idle or in the done cycle
//   target      0=cdac 1=pdac 2=adc 3=ddd, latched at start
//   tx_data     word to shift out, latched at start
//   miso        per-target serial return, bit index = target
//   busy, done  transfer in progress / one-cycle completion pulse
//   rx_data     last captured word, updated at done
//   cs_n        per-target chip select (active low, one-hot)
//   sclk, mosi  serial clock (idle low) and serial data
module spi_sequencer #(
  parameter int WIDTH  = 16,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       target,
  input  logic [WIDTH-1:0] tx_data,
  input  logic [3:0]       miso,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic [3:0]       cs_n,
  output logic             sclk,
  output logic             mosi
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int CW = $clog2(CLKDIV + 1);

  logic [2:0]       state;
  logic [CW-1:0]    div_cnt;
  logic [5:0]       bit_cnt;
  logic [1:0]       tgt;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] tx_nxt;
  logic             div_end;
  logic             last_bit;

  assign div_end  = (div_cnt == CW'(CLKDIV - 1));
  assign last_bit = (bit_cnt == 6'(WIDTH - 1));
  // Shifting through a full-width temporary keeps WIDTH=1 legal.
  assign tx_nxt   = tx_sh << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tgt     <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      cs_n    <= 4'hF;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // The done cycle accepts a new start so back-to-back transfers see
        // cs_n high for exactly one cycle.
        S_IDLE, S_DONE: begin
          cs_n <= 4'hF;
          busy <= 1'b0;
          sclk <= 1'b0;
          if (start) begin
            tgt     <= target;
            tx_sh   <= tx_data;
            rx_sh   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b1;
            cs_n    <= ~(4'b0001 << target);
            mosi    <= tx_data[WIDTH-1];
            state   <= S_SETUP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            state   <= S_LOW;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // Rising sclk and the MISO sample share one edge.
        S_LOW: begin
          if (div_end) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            rx_sh   <= (rx_sh << 1) | WIDTH'(miso[tgt]);
            state   <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // MOSI only changes on the falling edge, never under a high sclk.
        S_HIGH: begin
          if (div_end) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            if (last_bit) begin
              state <= S_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_sh   <= tx_nxt;
              mosi    <= tx_nxt[WIDTH-1];
              state   <= S_LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (div_end) begin
            div_cnt <= '0;
            cs_n    <= 4'hF;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
            state   <= S_DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          div_cnt <= '0;
          bit_cnt <= '0;
          tgt     <= '0;
          tx_sh   <= '0;
          rx_sh   <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          rx_data <= '0;
          cs_n    <= 4'hF;
          sclk    <= 1'b0;
          mosi    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sequencer.sv
// Directed bench for spi_sequencer: default instance (16 bit, CLKDIV 4) plus
// an 8-bit CLKDIV=1 instance. A slave model on miso[2] returns 16'h1234 MSB
// first, changing on sclk fall; miso[0] is tied high, the others low.
module tb_spi_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  target;
  logic [15:0] tx_data;
  logic [3:0]  miso;
  logic        busy, done, sclk, mosi;
  logic [15:0] rx_data;
  logic [3:0]  cs_n;

  logic        start8;
  logic [1:0]  target8;
  logic [7:0]  tx8;
  logic        busy8, done8, sclk8, mosi8;
  logic [7:0]  rx8;
  logic [3:0]  cs8;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] pat = 16'h1234;
  int          fcnt;

  always #5 clk = ~clk;

  always @(negedge sclk or posedge cs_n[2]) begin
    if (cs_n[2]) fcnt <= 0;
    else         fcnt <= fcnt + 1;
  end

  assign miso = {1'b0, (fcnt < 16) ? pat[15 - fcnt] : 1'b0, 1'b0, 1'b1};

  spi_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .target(target), .tx_data(tx_data),
    .miso(miso), .busy(busy), .done(done), .rx_data(rx_data), .cs_n(cs_n),
    .sclk(sclk), .mosi(mosi)
  );

  spi_sequencer #(.WIDTH(8), .CLKDIV(1)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .target(target8), .tx_data(tx8),
    .miso(miso), .busy(busy8), .done(done8), .rx_data(rx8), .cs_n(cs8),
    .sclk(sclk8), .mosi(mosi8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] t, input logic [15:0] d, input logic [3:0] ecs);
    target  = t;
    tx_data = d;
    start   = 1'b1;
    step();
    start   = 1'b0;
    chk("cs_at_start", {28'd0, cs_n}, {28'd0, ecs});
    chk("busy_at_start", {31'd0, busy}, 32'd1);
  endtask

  // Follows one transfer from the sample after its start edge up to done.
  task automatic monitor(input string tag, input logic [3:0] ecs, input logic [15:0] etx,
                         input logic [15:0] erx, input int repulse_at, input int hold_at,
                         input logic [15:0] hold_tx);
    int          rises  = 0;
    int          cs_ok  = 0;
    int          bsy_ok = 0;
    int          dcyc   = -1;
    logic [15:0] cap    = '0;
    logic        ps;
    ps = sclk;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (sclk && !ps) begin
        rises++;
        cap = {cap[14:0], mosi};
      end
      ps = sclk;
      if (done) begin
        dcyc = c;
        break;
      end
      if (cs_n == ecs) cs_ok++;
      if (busy) bsy_ok++;
      if (c == repulse_at) begin
        start   = 1'b1;
        tx_data = 16'hFFFF;
      end
      if (c == repulse_at + 1) start = 1'b0;
      if (c == hold_at) begin
        start   = 1'b1;
        tx_data = hold_tx;
      end
    end
    chk({tag, "_done_latency"}, dcyc, 32'd136);
    chk({tag, "_sclk_rises"}, rises, 32'd16);
    chk({tag, "_mosi_word"}, {16'd0, cap}, {16'd0, etx});
    chk({tag, "_cs_cycles"}, cs_ok, 32'd135);
    chk({tag, "_busy_cycles"}, bsy_ok, 32'd135);
    chk({tag, "_rx_data"}, {16'd0, rx_data}, {16'd0, erx});
    chk({tag, "_cs_at_done"}, {28'd0, cs_n}, 32'hF);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs_n"}, {28'd0, cs_n}, 32'hF);
    chk({tag, "_sclk"}, {31'd0, sclk}, 32'd0);
    chk({tag, "_mosi"}, {31'd0, mosi}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_rx_data"}, {16'd0, rx_data}, 32'd0);
  endtask

  initial begin
    int          rises;
    int          toggles;
    int          dcyc;
    logic [7:0]  cap8;
    logic        ps;

    reset   = 1'b1;
    start   = 1'b0;
    target  = 2'd0;
    tx_data = 16'h0;
    start8  = 1'b0;
    target8 = 2'd1;
    tx8     = 8'h0;

    // Power-up reset, checked before any clock edge.
    #2;
    chk_reset("por");
    step();
    step();
    reset = 1'b0;
    step();

    // Basic write to cdac; miso[0] tied high.
    launch(2'd0, 16'hA5C3, 4'b1110);
    monitor("cdac", 4'b1110, 16'hA5C3, 16'hFFFF, 0, 0, 16'h0);
    step();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_cs", {28'd0, cs_n}, 32'hF);

    // ADC read with the slave model.
    step();
    launch(2'd2, 16'h0F0F, 4'b1011);
    monitor("adc", 4'b1011, 16'h0F0F, 16'h1234, 0, 0, 16'h0);
    step();
    step();

    // Reset while idle clears the held rx_data.
    reset = 1'b1;
    #2;
    chk_reset("idle_rst");
    step();
    reset = 1'b0;
    step();

    // Start re-pulsed mid-transfer is ignored; start held through done chains.
    launch(2'd0, 16'hA5C3, 4'b1110);
    monitor("busy_start", 4'b1110, 16'hA5C3, 16'hFFFF, 20, 100, 16'h5A3C);
    step();
    start = 1'b0;
    chk("b2b_cs_low", {28'd0, cs_n}, 32'hE);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    monitor("b2b", 4'b1110, 16'h5A3C, 16'hFFFF, 0, 0, 16'h0);
    step();

    // Reset after the fifth rising sclk takes effect without a clock edge.
    launch(2'd0, 16'h1357, 4'b1110);
    rises = 0;
    ps    = sclk;
    for (int c = 0; c < 200 && rises < 5; c++) begin
      step();
      if (sclk && !ps) rises++;
      ps = sclk;
    end
    chk("pre_rst_sclk_high", {31'd0, sclk}, 32'd1);
    reset = 1'b1;
    #2;
    chk("mid_rst_cs_n", {28'd0, cs_n}, 32'hF);
    chk("mid_rst_sclk", {31'd0, sclk}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    step();
    reset = 1'b0;
    step();
    launch(2'd0, 16'hC001, 4'b1110);
    monitor("after_rst", 4'b1110, 16'hC001, 16'hFFFF, 0, 0, 16'h0);
    step();

    // WIDTH=8, CLKDIV=1: sclk toggles every cycle, done at +18.
    tx8    = 8'h81;
    start8 = 1'b1;
    step();
    start8  = 1'b0;
    tx8     = 8'h00;
    rises   = 0;
    toggles = 0;
    dcyc    = -1;
    cap8    = '0;
    ps      = sclk8;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (sclk8 && !ps) begin
        rises++;
        cap8 = {cap8[6:0], mosi8};
      end
      if (c >= 2 && c <= 17 && sclk8 != ps) toggles++;
      ps = sclk8;
      if (done8) begin
        dcyc = c;
        break;
      end
    end
    chk("w8_done_latency", dcyc, 32'd18);
    chk("w8_sclk_rises", rises, 32'd8);
    chk("w8_toggles", toggles, 32'd16);
    chk("w8_mosi_word", {24'd0, cap8}, 32'h81);
    chk("w8_cs_at_done", {28'd0, cs8}, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
